tx_frame_buffer: RTL and testbench

- Byte-oriented TX staging buffer in the REF_CLK domain, sitting between SYS_CTRL result sources (ALU result, RegFile read data) and the UART TX path (TX data synchronizer → UART_TX).
- Packs each ALU result into two bytes and each RegFile read into one byte, then queues them in a small FIFO.
- Drains the FIFO one byte per UART transmission, holding valid until the synchronized TX busy flag confirms acceptance.

---
 rtl/tx_frame_buffer_pkg.sv | 16 +
 rtl/tx_frame_buffer_if.sv | 27 ++
 rtl/tx_frame_buffer_fifo.sv | 54 +++++
 rtl/tx_frame_buffer.sv | 109 ++++++++++
 tb/tb_tx_frame_buffer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_frame_buffer_pkg.sv
// Shared defaults and FSM state type for the UART TX staging buffer.
// Pure declarations: no logic, so no latency and no backpressure.
package tx_frame_buffer_pkg;

  localparam int TX_WIDTH        = 8;
  localparam int TX_ALU_WIDTH    = 16;
  localparam int TX_FIFO_DEPTH   = 8;
  localparam int TX_BUSY_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_LO = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tx_frame_buffer_if.sv
// Result-source strobes and the UART TX request/busy handshake.
// The slave side is the buffer; busy is the only backpressure towards it.
interface tx_frame_buffer_if #(
  parameter int WIDTH     = 8,
  parameter int ALU_WIDTH = 16
);
  logic [ALU_WIDTH-1:0] ALU_OUT;
  logic                 ALU_OUT_VLD;
  logic [WIDTH-1:0]     RF_RdData;
  logic                 RF_RdData_VLD;
  logic                 UART_TX_Busy;
  logic [WIDTH-1:0]     UART_TX_DATA;
  logic                 UART_TX_VLD;
  logic                 FIFO_FULL;
  logic                 DROP;
  logic                 TX_TIMEOUT;

  modport master (
    output ALU_OUT, ALU_OUT_VLD, RF_RdData, RF_RdData_VLD, UART_TX_Busy,
    input  UART_TX_DATA, UART_TX_VLD, FIFO_FULL, DROP, TX_TIMEOUT
  );

  modport slave (
    input  ALU_OUT, ALU_OUT_VLD, RF_RdData, RF_RdData_VLD, UART_TX_Busy,
    output UART_TX_DATA, UART_TX_VLD, FIFO_FULL, DROP, TX_TIMEOUT
  );
endinterface

// File: rtl/tx_frame_buffer_fifo.sv
// Single-clock FIFO, up to two writes and one read per cycle; read data is combinational from head.
// No internal backpressure: the caller must check free2/count/empty before writing or reading.
module sync_fifo_2w1r #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr2_en,
  input  logic                     wr1_en,
  input  logic [WIDTH-1:0]         wr_dat0,
  input  logic [WIDTH-1:0]         wr_dat1,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     free2
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_p1;
  logic [CW-1:0]    wr_num;

  assign wr_ptr_p1 = wr_ptr + AW'(1);
  assign wr_num    = wr2_en ? CW'(2) : (wr1_en ? CW'(1) : '0);

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + wr_num[AW-1:0];
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + wr_num - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr2_en) begin
      mem[wr_ptr]    <= wr_dat0;
      mem[wr_ptr_p1] <= wr_dat1;
    end else if (wr1_en) begin
      mem[wr_ptr]    <= wr_dat0;
    end
  end

  assign rd_dat = mem[rd_ptr];
  assign empty  = (count == '0);
  assign free2  = (count <= CW'(DEPTH - 2));
endmodule

// File: rtl/tx_frame_buffer.sv
// Packs ALU results (2 bytes, LSB first) and RF reads (1 byte) into a FIFO and feeds UART TX; push-to-valid 1 cycle.
// Frames without room are dropped whole (DROP); a request busy never acknowledges is abandoned (TX_TIMEOUT).
module tx_frame_buffer
  import tx_frame_buffer_pkg::*;
#(
  parameter int WIDTH        = TX_WIDTH,
  parameter int ALU_WIDTH    = TX_ALU_WIDTH,
  parameter int DEPTH        = TX_FIFO_DEPTH,
  parameter int BUSY_TIMEOUT = TX_BUSY_TIMEOUT
) (
  input  logic               CLK,
  input  logic               RST,
  tx_frame_buffer_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  logic [CW-1:0]    fifo_count;
  logic             fifo_empty, fifo_free2, free1;
  logic             alu_push, rf_push, pop, drop_nx;
  logic [WIDTH-1:0] wr_lo, rd_dat;

  tx_state_t        state_q, state_nx;
  logic [TW-1:0]    tmr_q, tmr_nx;
  logic [WIDTH-1:0] dat_q, dat_nx;
  logic             vld_q, vld_nx, tmo_q, tmo_nx, drop_q;

  // Space is judged on the count at the start of the cycle; a same-cycle pop does not help.
  assign free1    = (fifo_count != CW'(DEPTH));
  assign alu_push = bus.ALU_OUT_VLD & fifo_free2;
  assign rf_push  = bus.RF_RdData_VLD & ~bus.ALU_OUT_VLD & free1;
  assign drop_nx  = (bus.ALU_OUT_VLD & ~fifo_free2) | (bus.RF_RdData_VLD & ~rf_push);
  assign wr_lo    = bus.ALU_OUT_VLD ? bus.ALU_OUT[WIDTH-1:0] : bus.RF_RdData;

  sync_fifo_2w1r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .wr2_en  (alu_push),
    .wr1_en  (rf_push),
    .wr_dat0 (wr_lo),
    .wr_dat1 (bus.ALU_OUT[ALU_WIDTH-1:WIDTH]),
    .rd_en   (pop),
    .rd_dat  (rd_dat),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .free2   (fifo_free2)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      tmr_q   <= tmr_nx;
      dat_q   <= dat_nx;
      vld_q   <= vld_nx;
      tmo_q   <= tmo_nx;
      drop_q  <= drop_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    tmr_nx   = tmr_q;
    dat_nx   = dat_q;
    vld_nx   = vld_q;
    tmo_nx   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !bus.UART_TX_Busy) begin
          pop      = 1'b1;
          dat_nx   = rd_dat;
          vld_nx   = 1'b1;
          tmr_nx   = '0;
          state_nx = REQ;
        end
      end
      REQ: begin
        if (bus.UART_TX_Busy) begin
          vld_nx   = 1'b0;
          state_nx = WAIT_LO;
        end else if (tmr_q == TW'(BUSY_TIMEOUT - 1)) begin
          // The byte is abandoned rather than retried.
          vld_nx   = 1'b0;
          tmo_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          tmr_nx   = tmr_q + TW'(1);
        end
      end
      WAIT_LO: begin
        if (!bus.UART_TX_Busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.UART_TX_DATA = dat_q;
  assign bus.UART_TX_VLD  = vld_q;
  assign bus.FIFO_FULL    = ~fifo_free2;
  assign bus.DROP         = drop_q;
  assign bus.TX_TIMEOUT   = tmo_q;
endmodule

// File: tb/tb_tx_frame_buffer.sv
// Bench for tx_frame_buffer: queue-based byte model checked every cycle, plus directed literal scenarios.
module tb_tx_frame_buffer;
  localparam int DEPTH = 8;
  localparam int TO    = 4;

  logic clk = 1'b0;
  logic rst_n;

  tx_frame_buffer_if #(.WIDTH(8), .ALU_WIDTH(16)) bus_if ();

  tx_frame_buffer #(.WIDTH(8), .ALU_WIDTH(16), .DEPTH(DEPTH), .BUSY_TIMEOUT(TO)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  byte unsigned mq[$];
  byte unsigned tx_log[$];
  int drop_seen = 0;
  int tmo_seen = 0;

  bit p_av, p_rv, p_busy, p_vld;
  logic [15:0] p_alu;
  logic [7:0]  p_rf, p_dat;
  int req_lo = 0;
  int stall = 0;

  int bmode = 0;     // 0: responder, 1: busy forced high, 2: busy forced low
  bit brnd = 0;
  int cfg_delay = 3;
  int cfg_hold = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input bit av, input logic [15:0] a, input bit rv, input logic [7:0] r);
    bus_if.ALU_OUT_VLD   = av;
    bus_if.ALU_OUT       = a;
    bus_if.RF_RdData_VLD = rv;
    bus_if.RF_RdData     = r;
    step(1);
    bus_if.ALU_OUT_VLD   = 1'b0;
    bus_if.RF_RdData_VLD = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    step(2);
    while ((mq.size() != 0 || bus_if.UART_TX_VLD || bus_if.UART_TX_Busy) && n < 2000) begin
      step(1);
      n++;
    end
    n_chk++;
    if (n >= 2000) begin
      n_fail++;
      $display("FAIL drain_%s: still %0d queued after %0d cycles", name, mq.size(), n);
    end
    step(3);
  endtask

  // Model: outputs after edge k follow from the inputs sampled before edge k.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      p_av = 0; p_rv = 0; p_busy = 0; p_vld = 0;
      p_alu = '0; p_rf = '0; p_dat = '0;
      req_lo = 0;
      stall = 0;
    end else begin
      int  cnt_pre;
      bit  exp_drop, exp_tmo;
      byte unsigned b;
      cnt_pre  = mq.size();
      exp_drop = 0;
      exp_tmo  = 0;
      if (p_av) begin
        if (DEPTH - cnt_pre >= 2) begin
          mq.push_back(p_alu[7:0]);
          mq.push_back(p_alu[15:8]);
        end else exp_drop = 1;
        if (p_rv) exp_drop = 1;
      end else if (p_rv) begin
        if (cnt_pre < DEPTH) mq.push_back(p_rf);
        else exp_drop = 1;
      end

      if (p_vld) begin
        if (p_busy) chk("vld_drop_on_busy", bus_if.UART_TX_VLD, 0);
        else begin
          req_lo++;
          if (req_lo == TO) begin
            exp_tmo = 1;
            chk("vld_drop_on_timeout", bus_if.UART_TX_VLD, 0);
          end else begin
            chk("vld_hold", bus_if.UART_TX_VLD, 1);
            chk("data_stable", bus_if.UART_TX_DATA, p_dat);
          end
        end
      end else if (bus_if.UART_TX_VLD) begin
        chk("pop_busy_low", p_busy, 0);
        chk("pop_nonempty", cnt_pre != 0, 1);
        if (cnt_pre != 0) begin
          b = mq.pop_front();
          chk("tx_byte_order", bus_if.UART_TX_DATA, b);
        end
        tx_log.push_back(bus_if.UART_TX_DATA);
        req_lo = 0;
      end

      chk("tx_timeout", bus_if.TX_TIMEOUT, exp_tmo);
      chk("drop", bus_if.DROP, exp_drop);
      chk("fifo_full", bus_if.FIFO_FULL, (DEPTH - mq.size()) < 2);

      if (!bus_if.UART_TX_VLD && !bus_if.UART_TX_Busy && mq.size() > 0) stall++;
      else stall = 0;
      if (stall > 3) begin
        n_chk++;
        n_fail++;
        $display("FAIL tx_stall: %0d bytes queued, no request for %0d cycles", mq.size(), stall);
        stall = 0;
      end

      if (bus_if.DROP) drop_seen++;
      if (bus_if.TX_TIMEOUT) tmo_seen++;
      p_av   = bus_if.ALU_OUT_VLD;
      p_rv   = bus_if.RF_RdData_VLD;
      p_alu  = bus_if.ALU_OUT;
      p_rf   = bus_if.RF_RdData;
      p_busy = bus_if.UART_TX_Busy;
      p_vld  = bus_if.UART_TX_VLD;
      p_dat  = bus_if.UART_TX_DATA;
    end
  end

  // UART stand-in: raises busy a few cycles after seeing a request, holds it, then releases.
  initial begin
    int r_cnt, r_hold, r_delay;
    r_cnt = 0; r_hold = 0; r_delay = 3;
    forever begin
      @(posedge clk);
      #2;
      if (bmode == 1) begin
        bus_if.UART_TX_Busy = 1'b1; r_cnt = 0; r_hold = 0;
      end else if (bmode == 2) begin
        bus_if.UART_TX_Busy = 1'b0; r_cnt = 0; r_hold = 0;
      end else if (bus_if.UART_TX_Busy) begin
        r_hold--;
        if (r_hold <= 0) bus_if.UART_TX_Busy = 1'b0;
      end else if (bus_if.UART_TX_VLD) begin
        r_cnt++;
        if (r_cnt >= r_delay) begin
          bus_if.UART_TX_Busy = 1'b1;
          r_cnt   = 0;
          r_hold  = brnd ? int'($urandom_range(1, 6)) : cfg_hold;
          r_delay = brnd ? int'($urandom_range(1, 3)) : cfg_delay;
        end
      end else r_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, d0, t0, hi;
    byte unsigned ovf_exp[8];
    rst_n = 1'b0;
    bus_if.ALU_OUT = '0; bus_if.ALU_OUT_VLD = 1'b0;
    bus_if.RF_RdData = '0; bus_if.RF_RdData_VLD = 1'b0;
    bus_if.UART_TX_Busy = 1'b0;
    step(3);
    chk("rst_vld", bus_if.UART_TX_VLD, 0);
    chk("rst_data", bus_if.UART_TX_DATA, 0);
    chk("rst_full", bus_if.FIFO_FULL, 0);
    chk("rst_drop", bus_if.DROP, 0);
    chk("rst_tmo", bus_if.TX_TIMEOUT, 0);
    rst_n = 1'b1;
    step(2);

    // Single RF byte, busy 3 cycles after request.
    base = tx_log.size(); d0 = drop_seen;
    push(0, 16'h0, 1, 8'hA5);
    chk("rf_lat_edge1", bus_if.UART_TX_VLD, 0);
    step(1);
    chk("rf_lat_edge2", bus_if.UART_TX_VLD, 1);
    chk("rf_data", bus_if.UART_TX_DATA, 8'hA5);
    wait_drain("rf");
    chk("rf_count", tx_log.size() - base, 1);
    chk("rf_byte", tx_log[base], 8'hA5);
    chk("rf_nodrop", drop_seen - d0, 0);

    // ALU frame with 10-cycle busy pulses.
    cfg_hold = 10;
    base = tx_log.size();
    push(1, 16'h1234, 0, 8'h0);
    wait_drain("alu");
    chk("alu_count", tx_log.size() - base, 2);
    chk("alu_lsb", tx_log[base], 8'h34);
    chk("alu_msb", tx_log[base + 1], 8'h12);

    // Overflow with busy held high.
    bmode = 1; step(2);
    base = tx_log.size();
    push(1, 16'h0201, 0, 8'h0);
    push(1, 16'h0403, 0, 8'h0);
    push(1, 16'h0605, 0, 8'h0);
    chk("ovf_full_at6", bus_if.FIFO_FULL, 0);
    push(1, 16'h0807, 0, 8'h0);
    chk("ovf_full_at8", bus_if.FIFO_FULL, 1);
    d0 = drop_seen;
    push(1, 16'h0A09, 0, 8'h0);
    step(1);
    chk("ovf_drop", drop_seen - d0, 1);
    chk("ovf_full_kept", bus_if.FIFO_FULL, 1);
    bmode = 0; cfg_hold = 4;
    wait_drain("ovf");
    chk("ovf_count", tx_log.size() - base, 8);
    ovf_exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 8; i++) chk("ovf_order", tx_log[base + i], ovf_exp[i]);

    // Simultaneous strobes: ALU wins, RF byte dropped.
    base = tx_log.size(); d0 = drop_seen;
    push(1, 16'hBEEF, 1, 8'h55);
    step(1);
    chk("sim_drop", drop_seen - d0, 1);
    wait_drain("sim");
    chk("sim_count", tx_log.size() - base, 2);
    chk("sim_lsb", tx_log[base], 8'hEF);
    chk("sim_msb", tx_log[base + 1], 8'hBE);

    // Timeout with busy tied low.
    bmode = 2; step(2);
    base = tx_log.size(); t0 = tmo_seen; hi = 0;
    push(0, 16'h0, 1, 8'h77);
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus_if.UART_TX_VLD) hi++;
    end
    chk("tmo_vld_cycles", hi, TO);
    chk("tmo_pulse", tmo_seen - t0, 1);
    chk("tmo_count", tx_log.size() - base, 1);
    chk("tmo_byte", tx_log[base], 8'h77);
    chk("tmo_full", bus_if.FIFO_FULL, 0);

    // Random traffic with a randomized busy responder.
    bmode = 0; brnd = 1;
    for (int i = 0; i < 1500; i++) begin
      bus_if.ALU_OUT_VLD   = ($urandom_range(0, 5) == 0);
      bus_if.ALU_OUT       = 16'($urandom);
      bus_if.RF_RdData_VLD = ($urandom_range(0, 4) == 0);
      bus_if.RF_RdData     = 8'($urandom);
      step(1);
    end
    bus_if.ALU_OUT_VLD = 1'b0; bus_if.RF_RdData_VLD = 1'b0;
    wait_drain("rnd");

    // Reset while a request is outstanding.
    brnd = 0; bmode = 1; step(2);
    push(1, 16'h2221, 0, 8'h0);
    push(1, 16'h4443, 0, 8'h0);
    push(0, 16'h0, 1, 8'h55);
    bmode = 0;
    hi = 0;
    while (!bus_if.UART_TX_VLD && hi < 50) begin
      step(1);
      hi++;
    end
    chk("rstmid_vld_seen", bus_if.UART_TX_VLD, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_vld", bus_if.UART_TX_VLD, 0);
    chk("rstmid_full", bus_if.FIFO_FULL, 0);
    chk("rstmid_data", bus_if.UART_TX_DATA, 0);
    bmode = 2;
    step(3);
    rst_n = 1'b1;
    base = tx_log.size();
    step(20);
    chk("rstmid_no_tx", tx_log.size() - base, 0);
    chk("rstmid_idle_vld", bus_if.UART_TX_VLD, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
